fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised, stateful successor to the combinational forwarding unit of the TinyRISC 5-stage pipeline (IF, OF, EX, MA, RW).
- Keeps its own registered descriptors of the EX, MA and RW instructions: valid, destination, is_load, is_multicycle.
- From these descriptors it produces:
  - forwarding selects for OF, EX and MA,
  - load-use stalls,
  - multi-cycle EX holds (mul/div/mod),
  - branch-flush squashing.

Parameters:
- REG_AW, 4, register address width (2**REG_AW architectural registers).
- MDIV_LAT, 4, EX occupancy in cycles for mul/div/mod; range 1..15, where 1 means single-cycle.
- RA_REG, 15, register written by call and read by ret.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- of_valid  in  1  OF latch holds a real instruction
- of_inst  in  32  instruction in OF
- branch_taken  in  1  EX resolved a taken branch this cycle
- stall_if_of  out  1  freeze PC, IF/OF and OF/EX latches
- bubble_ex  out  1  load a nop into the OF/EX latch
- hold_ex  out  1  EX keeps its instruction and operand latches
- bubble_ma  out  1  load a nop into the EX/MA latch
- fwd_of_rs1, fwd_of_rs2  out  1  take operand from RW result in OF
- fwd_ex_rs1, fwd_ex_rs2  out  2  EX operand source: 00 latch, 01 MA result, 10 RW result
- fwd_ma_st  out  1  store data taken from RW result

Behaviour:
- Instruction fields:
  - opcode [31:27], I [26], rd [25:22], rs1 [21:18], rs2 [17:14].
  - Fields are REG_AW bits wide, left-aligned after bit 26.
- Decode (pure functions):
  - Writes rd: add, sub, mul, div, mod, and, or, not, mov, lsl, lsr, asr, ld.
  - call writes RA_REG.
  - Reads rs1: binary ALU ops, cmp, ld, st.
  - Reads rs2 when I=0: binary ALU ops, cmp, not, mov.
  - st reads rd in MA; ret reads RA_REG.
  - nop, b, beq, bgt read nothing.
- Descriptors:
  - Three registered descriptors: ex_d, ma_d, rw_d.
  - Async reset: all valid bits 0, busy counter 0.
  - With no valid descriptor every output is 0; all outputs are 0 during reset.
- Normal advance (no hold):
  - rw_d <= ma_d; ma_d <= ex_d.
  - ex_d <= decode(of_inst) if of_valid, not stalled and no flush; otherwise ex_d <= bubble.
- Forwarding:
  - Combinational from the descriptors and of_inst.
  - A match requires: producer valid, producer writes, destination equal, consumer reads that field.
  - EX: the MA match has priority over the RW match.
  - A load in MA is never a forward source; the load-use stall guarantees this.
  - OF: RW match only.
  - MA store: rw_d matches the rd of the st in ma_d.
- Load-use stall:
  - Condition: ex_d is a valid ld AND the OF instruction reads ex_d.dest through rs1, rs2 or ret.
  - Action: stall_if_of=1 and bubble_ex=1 for exactly 1 cycle.
  - An OF st whose only dependency is its store-data rd does NOT stall; fwd_ma_st covers it later.
- Multi-cycle EX:
  - On entry of mul/div/mod into ex_d with MDIV_LAT>1, the busy counter loads MDIV_LAT-1.
  - While the counter is non-zero: hold_ex=1, stall_if_of=1, bubble_ma=1, and ex_d is held.
  - ma_d <= bubble; rw_d still advances.
  - The counter decrements each cycle; the cycle it reaches 0 is the normal advance.
  - fwd_ex_* are valid only in the entry cycle and are forced to 00 while held; the datapath latches operands on entry.
- Flush:
  - branch_taken squashes OF: ex_d <= bubble and stall_if_of is suppressed.
  - branch_taken overrides a simultaneous load-use stall.
  - A branch cannot be in EX while the busy counter is non-zero.
- Simultaneous events:
  - Busy hold dominates a load-use stall. The load-use check is re-evaluated after the hold.
- Reset mid-hold clears the counter immediately; the first cycle after release is a normal cycle.

Decomposition:
- Package tinyrisc_pkg holds:
  - opcode localparams,
  - field bit positions,
  - descriptor struct/width,
  - decode functions writes_rd, reads_rs1, reads_rs2, reads_rd_st, dest_of.
- One sub-module, fwd_hazard_match: a combinational comparator producing the per-source match bits. It is instantiated for the OF, EX and MA consumers.

Test Plan:
- add r1,r2,r3 then sub r4,r1,r5 back-to-back -> fwd_ex_rs1=01 in sub's EX cycle, no stall.
- add r1 / nop / or r6,r1,r1 -> fwd_ex_rs1=10 and fwd_ex_rs2=10. Also add r1 / nop / nop / and r7,r1,r2 -> fwd_of_rs1=1.
- ld r2,4[r3] then add r5,r2,r2 -> 1 cycle with stall_if_of=1 and bubble_ex=1, then fwd_ex_rs1=fwd_ex_rs2=10. Also ld r2 then st r2,0[r4] -> no stall, fwd_ma_st=1.
- MDIV_LAT=4: div r8,r9,r10 followed by add r1,r8,r8 -> hold_ex, stall_if_of and bubble_ma each high for 3 cycles, then add sees fwd_ex_rs1=01.
- Taken beq in EX while ld r2 is in EX-1 and a dependent add is in OF -> no stall, ex_d becomes bubble, and the next instruction (with no dependency) flows without a stall.
- rst_n asserted during the 2nd div hold cycle -> all outputs 0 immediately. After release, add r1,r2,r3 flows with no hold.

Source files
------------

// File: rtl/tinyrisc_pkg.sv
// TinyRISC ISA constants, pipeline descriptor type and decode helpers
// shared by the forwarding/hazard unit.
package tinyrisc_pkg;

   localparam int unsigned INST_W  = 32;
   localparam int unsigned OP_W    = 5;
   localparam int unsigned OP_LSB  = 27;
   localparam int unsigned IMM_BIT = 26;
   // Register fields are packed downward starting just below the I bit.
   localparam int unsigned FLD_TOP = 26;
   // Descriptor register fields are stored zero-extended to this width.
   localparam int unsigned FLD_W   = 8;

   localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
   localparam logic [OP_W-1:0] OP_MUL  = 5'd2;
   localparam logic [OP_W-1:0] OP_DIV  = 5'd3;
   localparam logic [OP_W-1:0] OP_MOD  = 5'd4;
   localparam logic [OP_W-1:0] OP_CMP  = 5'd5;
   localparam logic [OP_W-1:0] OP_AND  = 5'd6;
   localparam logic [OP_W-1:0] OP_OR   = 5'd7;
   localparam logic [OP_W-1:0] OP_NOT  = 5'd8;
   localparam logic [OP_W-1:0] OP_MOV  = 5'd9;
   localparam logic [OP_W-1:0] OP_LSL  = 5'd10;
   localparam logic [OP_W-1:0] OP_LSR  = 5'd11;
   localparam logic [OP_W-1:0] OP_ASR  = 5'd12;
   localparam logic [OP_W-1:0] OP_NOP  = 5'd13;
   localparam logic [OP_W-1:0] OP_LD   = 5'd14;
   localparam logic [OP_W-1:0] OP_ST   = 5'd15;
   localparam logic [OP_W-1:0] OP_BEQ  = 5'd16;
   localparam logic [OP_W-1:0] OP_BGT  = 5'd17;
   localparam logic [OP_W-1:0] OP_B    = 5'd18;
   localparam logic [OP_W-1:0] OP_CALL = 5'd19;
   localparam logic [OP_W-1:0] OP_RET  = 5'd20;

   // EX operand source encodings.
   localparam logic [1:0] FWD_LATCH = 2'b00;
   localparam logic [1:0] FWD_MA    = 2'b01;
   localparam logic [1:0] FWD_RW    = 2'b10;

   // Per-stage instruction descriptor: producer side (wr/dest) and
   // consumer side (rs1/rs2 read in EX, store data read in MA).
   typedef struct packed {
      logic             valid;
      logic             wr;
      logic [FLD_W-1:0] dest;
      logic             rd1;
      logic [FLD_W-1:0] src1;
      logic             rd2;
      logic [FLD_W-1:0] src2;
      logic             rd_st;
      logic [FLD_W-1:0] src_st;
      logic             is_load;
      logic             is_mc;
   } desc_t;

   localparam int unsigned DESC_W = $bits(desc_t);
   localparam desc_t DESC_NOP = '0;

   function automatic logic [OP_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
      return inst[OP_LSB +: OP_W];
   endfunction

   // Register field idx (0=rd, 1=rs1, 2=rs2) for aw-bit register addresses.
   function automatic logic [FLD_W-1:0] field_of(input logic [INST_W-1:0] inst,
                                                 input int unsigned aw,
                                                 input int unsigned idx);
      logic [INST_W-1:0] sh;
      logic [INST_W-1:0] mask;
      sh   = inst >> (FLD_TOP - aw * (idx + 1));
      mask = (INST_W'(1) << aw) - INST_W'(1);
      return FLD_W'(sh & mask);
   endfunction

   function automatic logic is_binary(input logic [OP_W-1:0] op);
      return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
                        OP_AND, OP_OR, OP_LSL, OP_LSR, OP_ASR};
   endfunction

   function automatic logic writes_rd(input logic [OP_W-1:0] op);
      return is_binary(op) | (op == OP_NOT) | (op == OP_MOV) | (op == OP_LD);
   endfunction

   function automatic logic reads_rs1(input logic [OP_W-1:0] op);
      return is_binary(op) | (op == OP_CMP) | (op == OP_LD) | (op == OP_ST);
   endfunction

   function automatic logic reads_rs2(input logic [OP_W-1:0] op, input logic imm);
      return ~imm & (is_binary(op) | (op == OP_CMP) | (op == OP_NOT) | (op == OP_MOV));
   endfunction

   function automatic logic reads_rd_st(input logic [OP_W-1:0] op);
      return op == OP_ST;
   endfunction

   function automatic logic [FLD_W-1:0] dest_of(input logic [INST_W-1:0] inst,
                                                input int unsigned aw,
                                                input logic [FLD_W-1:0] ra);
      return (opcode_of(inst) == OP_CALL) ? ra : field_of(inst, aw, 0);
   endfunction

   // Full descriptor of a valid instruction; ret reads ra through the rs1 path.
   function automatic desc_t decode_desc(input logic [INST_W-1:0] inst,
                                         input int unsigned aw,
                                         input logic [FLD_W-1:0] ra);
      desc_t           d;
      logic [OP_W-1:0] op;
      op        = opcode_of(inst);
      d         = DESC_NOP;
      d.valid   = 1'b1;
      d.wr      = writes_rd(op) | (op == OP_CALL);
      d.dest    = dest_of(inst, aw, ra);
      d.rd1     = reads_rs1(op) | (op == OP_RET);
      d.src1    = (op == OP_RET) ? ra : field_of(inst, aw, 1);
      d.rd2     = reads_rs2(op, inst[IMM_BIT]);
      d.src2    = field_of(inst, aw, 2);
      d.rd_st   = reads_rd_st(op);
      d.src_st  = field_of(inst, aw, 0);
      d.is_load = (op == OP_LD);
      d.is_mc   = op inside {OP_MUL, OP_DIV, OP_MOD};
      return d;
   endfunction

endpackage

// File: rtl/fwd_hazard_match.sv
// Compares N consumer register reads against one producer destination.
module fwd_hazard_match
   import tinyrisc_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]            src_use,
   input  logic [N-1:0][FLD_W-1:0] src_reg,
   input  logic                    prod_live,
   input  logic [FLD_W-1:0]        prod_dest,
   output logic [N-1:0]            hit
);

   // One equality comparator per consumer read port.
   for (genvar g = 0; g < N; g++) begin : g_cmp
      assign hit[g] = src_use[g] & prod_live & (src_reg[g] == prod_dest);
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Stateful forwarding and hazard unit for the TinyRISC 5-stage pipeline.
// Tracks EX/MA/RW descriptors and derives bypass selects, load-use stalls,
// multi-cycle EX holds and branch squashing from them.
module fwd_hazard_unit
   import tinyrisc_pkg::*;
#(
   parameter int unsigned REG_AW   = 4,
   parameter int unsigned MDIV_LAT = 4,
   parameter int unsigned RA_REG   = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              of_valid,
   input  logic [INST_W-1:0] of_inst,
   input  logic              branch_taken,
   output logic              stall_if_of,
   output logic              bubble_ex,
   output logic              hold_ex,
   output logic              bubble_ma,
   output logic              fwd_of_rs1,
   output logic              fwd_of_rs2,
   output logic [1:0]        fwd_ex_rs1,
   output logic [1:0]        fwd_ex_rs2,
   output logic              fwd_ma_st
);

   localparam int unsigned      CNT_W     = 4;
   localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(MDIV_LAT - 1);
   localparam logic             MC_MULTI  = (MDIV_LAT > 1);
   localparam logic [FLD_W-1:0] RA_FLD    = FLD_W'(RA_REG);

   desc_t            ex_d, ma_d, rw_d;
   desc_t            ex_n, ma_n, rw_n;
   desc_t            of_d;
   logic [CNT_W-1:0] busy_q, busy_n;
   logic             ex_fresh_q, ex_fresh_n;
   logic             busy, flush, lu_stall;
   logic [1:0]       of_rw_hit, of_ex_hit, ex_ma_hit, ex_rw_hit;
   logic [0:0]       ma_rw_hit;
   logic             unused_rw;

   // RW is only ever a producer; its consumer fields are dead.
   assign unused_rw = ^{rw_d.rd1, rw_d.src1, rw_d.rd2, rw_d.src2,
                        rw_d.rd_st, rw_d.src_st, rw_d.is_load, rw_d.is_mc};

   // Decode the OF instruction; an empty OF latch looks like a bubble.
   always_comb begin
      of_d = DESC_NOP;
      if (of_valid) of_d = decode_desc(of_inst, REG_AW, RA_FLD);
   end

   fwd_hazard_match #(.N(2)) u_of_rw (
      .src_use   ({of_d.rd2, of_d.rd1}),
      .src_reg   ({of_d.src2, of_d.src1}),
      .prod_live (rw_d.valid & rw_d.wr),
      .prod_dest (rw_d.dest),
      .hit       (of_rw_hit)
   );

   // Only a load in EX can create a dependency OF must wait for.
   fwd_hazard_match #(.N(2)) u_of_ex (
      .src_use   ({of_d.rd2, of_d.rd1}),
      .src_reg   ({of_d.src2, of_d.src1}),
      .prod_live (ex_d.valid & ex_d.wr & ex_d.is_load),
      .prod_dest (ex_d.dest),
      .hit       (of_ex_hit)
   );

   // Load data is not available in MA, so a load there never forwards.
   fwd_hazard_match #(.N(2)) u_ex_ma (
      .src_use   ({ex_d.rd2, ex_d.rd1}),
      .src_reg   ({ex_d.src2, ex_d.src1}),
      .prod_live (ma_d.valid & ma_d.wr & ~ma_d.is_load),
      .prod_dest (ma_d.dest),
      .hit       (ex_ma_hit)
   );

   fwd_hazard_match #(.N(2)) u_ex_rw (
      .src_use   ({ex_d.rd2, ex_d.rd1}),
      .src_reg   ({ex_d.src2, ex_d.src1}),
      .prod_live (rw_d.valid & rw_d.wr),
      .prod_dest (rw_d.dest),
      .hit       (ex_rw_hit)
   );

   fwd_hazard_match #(.N(1)) u_ma_rw (
      .src_use   (ma_d.rd_st),
      .src_reg   (ma_d.src_st),
      .prod_live (rw_d.valid & rw_d.wr),
      .prod_dest (rw_d.dest),
      .hit       (ma_rw_hit)
   );

   // Hazard decisions and forwarding selects; the busy hold dominates all.
   always_comb begin
      busy        = (busy_q != '0);
      flush       = branch_taken & ~busy;
      lu_stall    = (|of_ex_hit) & ~busy & ~branch_taken;
      stall_if_of = busy | lu_stall;
      bubble_ex   = lu_stall;
      hold_ex     = busy;
      bubble_ma   = busy;
      fwd_of_rs1  = of_rw_hit[0];
      fwd_of_rs2  = of_rw_hit[1];
      fwd_ex_rs1  = FWD_LATCH;
      fwd_ex_rs2  = FWD_LATCH;
      // Operands are latched on EX entry, so held cycles read the latch.
      if (ex_fresh_q) begin
         if (ex_ma_hit[0])      fwd_ex_rs1 = FWD_MA;
         else if (ex_rw_hit[0]) fwd_ex_rs1 = FWD_RW;
         if (ex_ma_hit[1])      fwd_ex_rs2 = FWD_MA;
         else if (ex_rw_hit[1]) fwd_ex_rs2 = FWD_RW;
      end
      fwd_ma_st   = ma_rw_hit[0];
   end

   // Next descriptors: hold EX while busy, otherwise advance and admit OF.
   always_comb begin
      ex_n       = ex_d;
      ma_n       = ma_d;
      rw_n       = ma_d;
      busy_n     = busy_q;
      ex_fresh_n = 1'b1;
      if (busy) begin
         ma_n       = DESC_NOP;
         busy_n     = busy_q - CNT_W'(1);
         ex_fresh_n = 1'b0;
      end else begin
         ma_n = ex_d;
         if (of_d.valid && !lu_stall && !flush) begin
            ex_n = of_d;
            if (of_d.is_mc && MC_MULTI) busy_n = BUSY_LOAD;
         end else begin
            ex_n = DESC_NOP;
         end
      end
   end

   // Descriptor and busy-counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_d       <= DESC_NOP;
         ma_d       <= DESC_NOP;
         rw_d       <= DESC_NOP;
         busy_q     <= '0;
         ex_fresh_q <= 1'b0;
      end else begin
         ex_d       <= ex_n;
         ma_d       <= ma_n;
         rw_d       <= rw_n;
         busy_q     <= busy_n;
         ex_fresh_q <= ex_fresh_n;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector bench for fwd_hazard_unit (MDIV_LAT=4, REG_AW=4, RA=15).
module tb_fwd_hazard_unit;

   localparam logic [4:0] T_ADD = 5'd0;
   localparam logic [4:0] T_SUB = 5'd1;
   localparam logic [4:0] T_DIV = 5'd3;
   localparam logic [4:0] T_AND = 5'd6;
   localparam logic [4:0] T_OR  = 5'd7;
   localparam logic [4:0] T_NOP = 5'd13;
   localparam logic [4:0] T_LD  = 5'd14;
   localparam logic [4:0] T_ST  = 5'd15;
   localparam logic [4:0] T_RET = 5'd20;
   localparam logic [10:0] Z = 11'd0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        of_valid = 1'b0;
   logic [31:0] of_inst = 32'd0;
   logic        branch_taken = 1'b0;
   logic        stall_if_of, bubble_ex, hold_ex, bubble_ma;
   logic        fwd_of_rs1, fwd_of_rs2, fwd_ma_st;
   logic [1:0]  fwd_ex_rs1, fwd_ex_rs2;
   logic [10:0] outs;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic        v;
      logic [31:0] inst;
      logic        bt;
      logic [10:0] exp;
      string       tag;
   } vec_t;
   vec_t vq[$];

   fwd_hazard_unit #(.REG_AW(4), .MDIV_LAT(4), .RA_REG(15)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .of_valid     (of_valid),
      .of_inst      (of_inst),
      .branch_taken (branch_taken),
      .stall_if_of  (stall_if_of),
      .bubble_ex    (bubble_ex),
      .hold_ex      (hold_ex),
      .bubble_ma    (bubble_ma),
      .fwd_of_rs1   (fwd_of_rs1),
      .fwd_of_rs2   (fwd_of_rs2),
      .fwd_ex_rs1   (fwd_ex_rs1),
      .fwd_ex_rs2   (fwd_ex_rs2),
      .fwd_ma_st    (fwd_ma_st)
   );

   assign outs = {stall_if_of, bubble_ex, hold_ex, bubble_ma, fwd_of_rs1,
                  fwd_of_rs2, fwd_ex_rs1, fwd_ex_rs2, fwd_ma_st};

   always #5 clk = ~clk;

   function automatic logic [31:0] enc(input logic [4:0] op, input logic imm,
                                       input logic [3:0] rd, input logic [3:0] rs1,
                                       input logic [3:0] rs2);
      return {op, imm, rd, rs1, rs2, 14'd0};
   endfunction

   // Expected output word, same bit order as outs.
   function automatic logic [10:0] o(input logic s, input logic bx, input logic h,
                                     input logic bm, input logic f1, input logic f2,
                                     input logic [1:0] e1, input logic [1:0] e2,
                                     input logic st);
      return {s, bx, h, bm, f1, f2, e1, e2, st};
   endfunction

   task automatic add_v(input logic v, input logic [31:0] inst, input logic bt,
                        input logic [10:0] e, input string tag);
      vec_t t;
      t.v = v; t.inst = inst; t.bt = bt; t.exp = e; t.tag = tag;
      vq.push_back(t);
   endtask

   task automatic check(input string tag, input logic [10:0] e);
      total++;
      if (outs !== e) begin
         bad++;
         $display("FAIL %s got=%b want=%b (stall,bex,hold,bma,of1,of2,ex1,ex2,mst)",
                  tag, outs, e);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic bt);
      of_valid = v; of_inst = inst; branch_taken = bt;
   endtask

   initial begin
      // add r1,r2,r3 ; sub r4,r1,r5 -> MA bypass
      add_v(1, enc(T_ADD,0,1,2,3), 0, Z, "A_add");
      add_v(1, enc(T_SUB,0,4,1,5), 0, Z, "A_sub");
      add_v(0, 0, 0, o(0,0,0,0,0,0,2'b01,2'b00,0), "A_ex_ma");
      add_v(0, 0, 0, Z, "A_d0");
      add_v(0, 0, 0, Z, "A_d1");
      // add r1 ; nop ; or r6,r1,r1 -> RW bypass on both operands
      add_v(1, enc(T_ADD,0,1,2,3), 0, Z, "B_add");
      add_v(1, enc(T_NOP,0,0,0,0), 0, Z, "B_nop");
      add_v(1, enc(T_OR,0,6,1,1), 0, Z, "B_or");
      add_v(1, enc(T_NOP,0,0,0,0), 0, o(0,0,0,0,0,0,2'b10,2'b10,0), "B_ex_rw");
      add_v(0, 0, 0, Z, "B_d0");
      add_v(0, 0, 0, Z, "B_d1");
      add_v(0, 0, 0, Z, "B_d2");
      // add r1 ; nop ; nop ; and r7,r1,r2 -> OF bypass on rs1
      add_v(1, enc(T_ADD,0,1,2,3), 0, Z, "B2_add");
      add_v(1, enc(T_NOP,0,0,0,0), 0, Z, "B2_nop0");
      add_v(1, enc(T_NOP,0,0,0,0), 0, Z, "B2_nop1");
      add_v(1, enc(T_AND,0,7,1,2), 0, o(0,0,0,0,1,0,2'b00,2'b00,0), "B2_of_rw");
      add_v(0, 0, 0, Z, "B2_d0");
      add_v(0, 0, 0, Z, "B2_d1");
      add_v(0, 0, 0, Z, "B2_d2");
      // ld r2,4[r3] ; add r5,r2,r2 -> one stall cycle then RW bypass
      add_v(1, enc(T_LD,1,2,3,0) | 32'd4, 0, Z, "C_ld");
      add_v(1, enc(T_ADD,0,5,2,2), 0, o(1,1,0,0,0,0,2'b00,2'b00,0), "C_lu_stall");
      add_v(1, enc(T_ADD,0,5,2,2), 0, Z, "C_add_retry");
      add_v(0, 0, 0, o(0,0,0,0,0,0,2'b10,2'b10,0), "C_ex_rw");
      add_v(0, 0, 0, Z, "C_d0");
      add_v(0, 0, 0, Z, "C_d1");
      // ld r2 ; st r2,0[r4] -> no stall, store data from RW
      add_v(1, enc(T_LD,1,2,3,0), 0, Z, "C2_ld");
      add_v(1, enc(T_ST,1,2,4,0), 0, Z, "C2_st_nostall");
      add_v(0, 0, 0, Z, "C2_d0");
      add_v(0, 0, 0, o(0,0,0,0,0,0,2'b00,2'b00,1), "C2_ma_st");
      add_v(0, 0, 0, Z, "C2_d1");
      // div r8,r9,r10 ; add r1,r8,r8 -> 3 hold cycles then MA bypass
      add_v(1, enc(T_DIV,0,8,9,10), 0, Z, "D_div");
      add_v(1, enc(T_ADD,0,1,8,8), 0, o(1,0,1,1,0,0,2'b00,2'b00,0), "D_hold1");
      add_v(1, enc(T_ADD,0,1,8,8), 0, o(1,0,1,1,0,0,2'b00,2'b00,0), "D_hold2");
      add_v(1, enc(T_ADD,0,1,8,8), 0, o(1,0,1,1,0,0,2'b00,2'b00,0), "D_hold3");
      add_v(1, enc(T_ADD,0,1,8,8), 0, Z, "D_release");
      add_v(0, 0, 0, o(0,0,0,0,0,0,2'b01,2'b01,0), "D_ex_ma");
      add_v(0, 0, 0, Z, "D_d0");
      add_v(0, 0, 0, Z, "D_d1");
      // ld r2 in EX, dependent add in OF, branch taken -> squash, no stall
      add_v(1, enc(T_LD,1,2,3,0), 0, Z, "E_ld");
      add_v(1, enc(T_ADD,0,5,2,2), 1, Z, "E_flush");
      add_v(1, enc(T_OR,0,6,5,7), 0, Z, "E_next");
      add_v(0, 0, 0, Z, "E_no_fwd_squashed");
      add_v(0, 0, 0, Z, "E_d0");
      add_v(0, 0, 0, Z, "E_d1");
      // ld r15 ; ret -> ret reads ra: load-use stall then RW bypass
      add_v(1, enc(T_LD,1,15,3,0), 0, Z, "G_ld_ra");
      add_v(1, enc(T_RET,0,0,0,0), 0, o(1,1,0,0,0,0,2'b00,2'b00,0), "G_ret_stall");
      add_v(1, enc(T_RET,0,0,0,0), 0, Z, "G_ret_retry");
      add_v(0, 0, 0, o(0,0,0,0,0,0,2'b10,2'b00,0), "G_ex_rw");
      add_v(0, 0, 0, Z, "G_d0");
      add_v(0, 0, 0, Z, "G_d1");

      // Reset with a live instruction in OF: everything must stay low.
      #1 rst_n = 1'b0;
      drive(1, enc(T_ADD,0,1,2,3), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset", Z);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int k = 0; k < vq.size(); k++) begin
         drive(vq[k].v, vq[k].inst, vq[k].bt);
         @(negedge clk);
         check($sformatf("%s[%0d]", vq[k].tag, k), vq[k].exp);
         @(posedge clk);
         #1;
      end

      // Reset in the 2nd div hold cycle, then normal flow after release.
      drive(1, enc(T_DIV,0,8,9,10), 0);
      @(negedge clk);
      check("F_div", Z);
      @(posedge clk);
      #1 drive(1, enc(T_ADD,0,1,8,8), 0);
      @(negedge clk);
      check("F_hold1", o(1,0,1,1,0,0,2'b00,2'b00,0));
      @(posedge clk);
      #1 check("F_hold2", o(1,0,1,1,0,0,2'b00,2'b00,0));
      #2 rst_n = 1'b0;
      #1 check("F_rst_mid_hold", Z);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1, enc(T_ADD,0,1,2,3), 0);
      @(negedge clk);
      check("F_post_add", Z);
      @(posedge clk);
      #1 drive(1, enc(T_SUB,0,4,1,5), 0);
      @(negedge clk);
      check("F_post_no_hold", Z);
      @(posedge clk);
      #1 drive(0, 32'd0, 0);
      @(negedge clk);
      check("F_post_ex_ma", o(0,0,0,0,0,0,2'b01,2'b00,0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
